// File: rtl/icache_pkg.sv
// Shared types, widths and helpers for the ICache refill/flush sequencing logic.
// Tag entries are stored as {valid, tag} with the valid bit in the MSB.
package icache_pkg;

    localparam int ICACHEWIDE   = 256;
    localparam int ICACHEDEEP   = 64;
    localparam int INDEXWIDE    = 6;
    localparam int TAGWIDE      = 20;
    localparam int LINEOFFSET   = 6;
    localparam int TAGENTRYWIDE = TAGWIDE + 1;

    localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
    localparam logic [2:0] ST_REQ_ENC   = 3'd1;
    localparam logic [2:0] ST_WAIT_ENC  = 3'd2;
    localparam logic [2:0] ST_WRITE_ENC = 3'd3;
    localparam logic [2:0] ST_DONE_ENC  = 3'd4;
    localparam logic [2:0] ST_FLUSH_ENC = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_REQ   = ST_REQ_ENC,
        ST_WAIT  = ST_WAIT_ENC,
        ST_WRITE = ST_WRITE_ENC,
        ST_DONE  = ST_DONE_ENC,
        ST_FLUSH = ST_FLUSH_ENC
    } state_e;

    function automatic logic [1:0] way_onehot(input logic way);
        return way ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & ~((32'd1 << LINEOFFSET) - 32'd1);
    endfunction

    function automatic logic [TAGENTRYWIDE-1:0] tag_entry(input logic valid,
                                                          input logic [TAGWIDE-1:0] tag);
        return {valid, tag};
    endfunction

endpackage

// File: rtl/icache_flush_walker.sv
// Set walker for cache invalidation: a start pulse runs idx over 0..DEEP-1, one set per
// cycle, then wraps to 0 and pulses done in the following cycle.
module icache_flush_walker
    import icache_pkg::*;
#(
    parameter int DEEP = ICACHEDEEP,
    parameter int IDXW = INDEXWIDE
) (
    input  logic            Clk,
    input  logic            Rest,
    input  logic            start,
    output logic            busy,
    output logic [IDXW-1:0] idx,
    output logic            last,
    output logic            done
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEEP - 1);

    logic            busy_r;
    logic [IDXW-1:0] idx_r;
    logic            done_r;

    // Set counter; start is ignored while a walk is already running.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            busy_r <= 1'b0;
            idx_r  <= {IDXW{1'b0}};
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (busy_r) begin
                if (idx_r == LAST_IDX) begin
                    busy_r <= 1'b0;
                    idx_r  <= {IDXW{1'b0}};
                    done_r <= 1'b1;
                end else begin
                    idx_r <= idx_r + {{(IDXW-1){1'b0}}, 1'b1};
                end
            end else if (start) begin
                busy_r <= 1'b1;
                idx_r  <= {IDXW{1'b0}};
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    assign busy = busy_r;
    assign idx  = idx_r;
    assign last = busy_r && (idx_r == LAST_IDX);
    assign done = done_r;

endmodule

// File: rtl/icache_refill_ctrl.sv
// ICache Stage1 SRAM sequencer: miss refill through the AXI bridge and full-array flush.
// Optional performance counters are built when ICACHE_PERF_CNT_EN is defined.
module icache_refill_ctrl
    import icache_pkg::*;
(
    input  logic                    Clk,
    input  logic                    Rest,
    input  logic                    MissValid,
    input  logic [31:0]             MissAddr,
    input  logic                    ReplaceWay,
    output logic                    MissReady,
    input  logic                    FlushReq,
    output logic                    FlushDone,
    output logic                    Stage1Stop,
    output logic                    AxiReqValid,
    output logic [31:0]             AxiReqAddr,
    input  logic                    AxiReqReady,
    input  logic                    AxiRespValid,
    input  logic [ICACHEWIDE-1:0]   AxiRespData,
    output logic                    WrEn,
    output logic [1:0]              WrWayMask,
    output logic [INDEXWIDE-1:0]    WrIndex,
    output logic [TAGENTRYWIDE-1:0] WrTag,
    output logic [ICACHEWIDE-1:0]   WrData,
    output logic                    RefillDone
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]             PerfMissCnt,
    output logic [31:0]             PerfStallCnt
`endif
);

    state_e                 state_r;
    logic [31:0]            miss_addr_r;
    logic                   way_r;
    logic [ICACHEWIDE-1:0]  line_r;
    logic                   kill_r;
    logic                   flush_pend_r;
    logic [INDEXWIDE-1:0]   wr_index_r;

    logic                   flush_start_s;
    logic                   walk_busy_s;
    logic                   walk_last_s;
    logic                   walk_done_s;
    logic [INDEXWIDE-1:0]   walk_idx_s;
    logic                   refill_wr_s;
    logic                   in_flush_s;

    // A pending flush is launched only from DONE so an in-flight refill always drains first.
    assign flush_start_s = ((state_r == ST_IDLE) && FlushReq) ||
                           ((state_r == ST_DONE) && (flush_pend_r || FlushReq));

    icache_flush_walker #(
        .DEEP (ICACHEDEEP),
        .IDXW (INDEXWIDE)
    ) u_walker (
        .Clk   (Clk),
        .Rest  (Rest),
        .start (flush_start_s),
        .busy  (walk_busy_s),
        .idx   (walk_idx_s),
        .last  (walk_last_s),
        .done  (walk_done_s)
    );

    // Refill/flush sequencer.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            state_r      <= ST_IDLE;
            miss_addr_r  <= 32'd0;
            way_r        <= 1'b0;
            line_r       <= {ICACHEWIDE{1'b0}};
            kill_r       <= 1'b0;
            flush_pend_r <= 1'b0;
            wr_index_r   <= {INDEXWIDE{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (flush_start_s) begin
                        state_r <= ST_FLUSH;
                    end else if (MissValid) begin
                        state_r     <= ST_REQ;
                        miss_addr_r <= MissAddr;
                        way_r       <= ReplaceWay;
                        wr_index_r  <= MissAddr[LINEOFFSET +: INDEXWIDE];
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (FlushReq) begin
                        kill_r       <= 1'b1;
                        flush_pend_r <= 1'b1;
                    end
                    if (AxiReqReady) begin
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (FlushReq) begin
                        kill_r       <= 1'b1;
                        flush_pend_r <= 1'b1;
                    end
                    if (AxiRespValid) begin
                        line_r  <= AxiRespData;
                        state_r <= ST_WRITE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WRITE: begin
                    if (FlushReq) begin
                        flush_pend_r <= 1'b1;
                    end
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    kill_r       <= 1'b0;
                    flush_pend_r <= 1'b0;
                    if (flush_start_s) begin
                        state_r <= ST_FLUSH;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    kill_r       <= 1'b0;
                    flush_pend_r <= 1'b0;
                    if (walk_last_s) begin
                        state_r    <= ST_IDLE;
                        wr_index_r <= walk_idx_s;
                    end else begin
                        state_r <= ST_FLUSH;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    kill_r       <= 1'b0;
                    flush_pend_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_flush_s  = (state_r == ST_FLUSH);
    assign refill_wr_s = (state_r == ST_WRITE) && !kill_r;

    // A same-cycle flush request wins over the miss, so the miss must not see ready.
    assign MissReady   = (state_r == ST_IDLE) && !flush_pend_r && !walk_busy_s && !FlushReq;
    assign Stage1Stop  = (state_r != ST_IDLE);
    assign AxiReqValid = (state_r == ST_REQ);
    assign AxiReqAddr  = AxiReqValid ? line_align(miss_addr_r) : 32'd0;
    assign WrEn        = refill_wr_s || in_flush_s;
    assign WrWayMask   = in_flush_s  ? 2'b11 :
                         refill_wr_s ? way_onehot(way_r) : 2'b00;
    assign WrIndex     = in_flush_s ? walk_idx_s : wr_index_r;
    assign WrTag       = refill_wr_s ?
                         tag_entry(1'b1, miss_addr_r[LINEOFFSET+INDEXWIDE +: TAGWIDE]) :
                         {TAGENTRYWIDE{1'b0}};
    assign WrData      = refill_wr_s ? line_r : {ICACHEWIDE{1'b0}};
    assign RefillDone  = (state_r == ST_DONE) && !kill_r && !flush_pend_r;
    assign FlushDone   = walk_done_s;

`ifdef ICACHE_PERF_CNT_EN
    logic        miss_accept_s;
    logic [31:0] perf_miss_r;
    logic [31:0] perf_stall_r;

    assign miss_accept_s = MissReady && MissValid;

    // Free-running miss and stall counters, wrapping modulo 2^32.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            perf_miss_r  <= 32'd0;
            perf_stall_r <= 32'd0;
        end else begin
            if (miss_accept_s) begin
                perf_miss_r <= perf_miss_r + 32'd1;
            end
            if (Stage1Stop) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
        end
    end

    assign PerfMissCnt  = perf_miss_r;
    assign PerfStallCnt = perf_stall_r;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized self-checking bench for icache_refill_ctrl; expected refill contents come from
// address arithmetic and expected event counts from a transaction-level tally.
module tb_icache_refill_ctrl;

    logic         Clk = 1'b0;
    logic         Rest = 1'b0;
    logic         MissValid = 1'b0;
    logic [31:0]  MissAddr = 32'd0;
    logic         ReplaceWay = 1'b0;
    logic         MissReady;
    logic         FlushReq = 1'b0;
    logic         FlushDone;
    logic         Stage1Stop;
    logic         AxiReqValid;
    logic [31:0]  AxiReqAddr;
    logic         AxiReqReady = 1'b0;
    logic         AxiRespValid = 1'b0;
    logic [255:0] AxiRespData = 256'd0;
    logic         WrEn;
    logic [1:0]   WrWayMask;
    logic [5:0]   WrIndex;
    logic [20:0]  WrTag;
    logic [255:0] WrData;
    logic         RefillDone;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  PerfMissCnt;
    logic [31:0]  PerfStallCnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_refill = 0, n_fdone = 0, n_hs = 0;
    int exp_refill = 0, exp_fdone = 0, exp_hs = 0;

    icache_refill_ctrl dut (
        .Clk          (Clk),
        .Rest         (Rest),
        .MissValid    (MissValid),
        .MissAddr     (MissAddr),
        .ReplaceWay   (ReplaceWay),
        .MissReady    (MissReady),
        .FlushReq     (FlushReq),
        .FlushDone    (FlushDone),
        .Stage1Stop   (Stage1Stop),
        .AxiReqValid  (AxiReqValid),
        .AxiReqAddr   (AxiReqAddr),
        .AxiReqReady  (AxiReqReady),
        .AxiRespValid (AxiRespValid),
        .AxiRespData  (AxiRespData),
        .WrEn         (WrEn),
        .WrWayMask    (WrWayMask),
        .WrIndex      (WrIndex),
        .WrTag        (WrTag),
        .WrData       (WrData),
        .RefillDone   (RefillDone)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .PerfMissCnt  (PerfMissCnt),
        .PerfStallCnt (PerfStallCnt)
`endif
    );

    always #5 Clk = ~Clk;

    // Event tally from the DUT outputs, compared against the expected tally at the end.
    always @(negedge Clk) begin
        if (Rest) begin
            if (RefillDone) n_refill++;
            if (FlushDone) n_fdone++;
            if (AxiReqValid && AxiReqReady) n_hs++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [299:0] obs, input logic [299:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_flush();
        int waited = 0;
        @(negedge Clk);
        while (!WrEn && waited < 4) begin
            waited++;
            @(negedge Clk);
        end
        check_val("flush_start", WrEn, 1);
        for (int k = 0; k < 64; k++) begin
            check_val("flush_set", {AxiReqValid, WrEn, WrWayMask, WrIndex, WrTag, WrData},
                      {1'b0, 1'b1, 2'b11, 6'(k), 21'd0, 256'd0});
            @(negedge Clk);
        end
        check_val("flush_done", {FlushDone, Stage1Stop}, 2'b10);
        exp_fdone++;
        step();
    endtask

    // flush_phase: 0 none, 1 flush during request, 2 flush during response wait.
    task automatic do_miss(input logic [31:0] addr, input logic way, input int rdy_dly,
                           input int rsp_dly, input int flush_phase);
        logic [255:0] data;
        logic [31:0]  line_addr;
        int unsigned  set_idx;
        logic [19:0]  tag_v;
        logic         killed;
        for (int w = 0; w < 8; w++) data[w*32 +: 32] = $urandom;
        line_addr = addr - (addr % 32'd64);
        set_idx   = (addr / 64) % 64;
        tag_v     = 20'(addr / 4096);
        killed    = (flush_phase != 0);

        MissValid = 1'b1; MissAddr = addr; ReplaceWay = way;
        @(negedge Clk);
        check_val("miss_ready", MissReady, 1);
        step();
        MissValid = 1'b0; MissAddr = $urandom; ReplaceWay = 1'($urandom);
        exp_hs++;
        for (int i = 0; i <= rdy_dly; i++) begin
            AxiReqReady = (i == rdy_dly);
            FlushReq = (flush_phase == 1 && i == 0);
            @(negedge Clk);
            check_val("req_valid", {AxiReqValid, Stage1Stop}, 2'b11);
            check_val("req_addr", AxiReqAddr, line_addr);
            step();
        end
        AxiReqReady = 1'b0; FlushReq = 1'b0;
        for (int j = 0; j <= rsp_dly; j++) begin
            AxiRespValid = (j == rsp_dly);
            AxiRespData = data;
            FlushReq = (flush_phase == 2 && j == 0);
            @(negedge Clk);
            check_val("wait_state", {AxiReqValid, Stage1Stop, WrEn}, 3'b010);
            step();
        end
        AxiRespValid = 1'b0; AxiRespData = ~data; FlushReq = 1'b0;
        @(negedge Clk);
        if (killed) begin
            check_val("killed_write", {WrEn, RefillDone}, 2'b00);
        end else begin
            check_val("wr_ctl", {WrEn, WrWayMask, WrIndex},
                      {1'b1, (way ? 2'b10 : 2'b01), 6'(set_idx)});
            check_val("wr_tag", WrTag, {1'b1, tag_v});
            check_val("wr_data", WrData, data);
            exp_refill++;
        end
        step();
        @(negedge Clk);
        check_val("refill_done", {RefillDone, Stage1Stop}, {~killed, 1'b1});
        step();
        if (killed) begin
            expect_flush();
        end else begin
            @(negedge Clk);
            check_val("back_idle", {Stage1Stop, MissReady, RefillDone}, 3'b010);
            step();
        end
    endtask

    initial begin
        #3;
        check_val("reset_state", {MissReady, Stage1Stop, AxiReqValid, WrEn, RefillDone, FlushDone},
                  6'b100000);
        @(negedge Clk);
        Rest = 1'b1;
        step();

        do_miss(32'h1C0012C4, 1'b1, 0, 0, 0);
        do_miss(32'h8765_4321, 1'b0, 5, 0, 0);

        // Flush and miss together in IDLE: miss refused, full flush, no AXI traffic.
        FlushReq = 1'b1; MissValid = 1'b1; MissAddr = 32'hDEAD_BEEF;
        @(negedge Clk);
        check_val("miss_blocked", MissReady, 0);
        step();
        FlushReq = 1'b0; MissValid = 1'b0;
        expect_flush();

        do_miss(32'h0000_0FC0, 1'b0, 1, 2, 2);
        do_miss(32'hFFFF_FFFF, 1'b1, 2, 1, 1);

        // Asynchronous reset in the middle of a response wait.
        MissValid = 1'b1; MissAddr = $urandom; ReplaceWay = 1'b0;
        step();
        MissValid = 1'b0; AxiReqReady = 1'b1;
        step();
        AxiReqReady = 1'b0;
        exp_hs++;
        @(negedge Clk);
        check_val("in_wait", {Stage1Stop, AxiReqValid}, 2'b10);
        #2 Rest = 1'b0;
        #1;
        check_val("async_reset", {Stage1Stop, AxiReqValid, WrEn, RefillDone, FlushDone, MissReady},
                  6'b000001);
        @(negedge Clk);
        Rest = 1'b1;
        step();

        for (int m = 0; m < 3; m++) do_miss($urandom, 1'($urandom), 0, 0, 0);
`ifdef ICACHE_PERF_CNT_EN
        check_val("perf_miss", PerfMissCnt, 3);
        check_val("perf_stall", PerfStallCnt, 12);
`endif

        for (int r = 0; r < 25; r++) begin
            int fp;
            fp = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
            do_miss($urandom, 1'($urandom), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), fp);
            repeat ($urandom_range(0, 2)) step();
        end

        step();
        check_val("refill_count", n_refill, exp_refill);
        check_val("flushdone_count", n_fdone, exp_fdone);
        check_val("axi_handshakes", n_hs, exp_hs);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
